bus_arbiter: RTL

//  Round-robin arbiter and sequencer for the shared 8-bit, 6-source system bus.
//  Six requesters (sources 0..5 map to bus inputs a..f) compete for the bus.
//  The block drives the bus select lines {s2,s1,s0} and a one-hot grant.

---
 rtl/bus_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter and sequencer for the shared 8-bit, 6-source system bus.
// Sources 0..5 (bus inputs a..f) request the bus; the winner receives a registered
// one-hot grant and the bus select {s2,s1,s0} is driven with its index. With no owner
// the select parks on ParkSel, where the bus outputs zero. An owner keeps the bus for
// at most MaxHold consecutive cycles while others wait, unless it holds lock.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_i        synchronous reset, active-high
//   req_i[5:0]   request per source, bit i = source i
//   lock_i       current owner asks to keep the bus past its tenure
//   gnt_o[5:0]   one-hot grant, zero when parked
//   s0_o..s2_o   bus select, owner index or ParkSel when parked
//   bus_valid_o  high while a grant is active
//   owner_o[2:0] current owner index, holds the last owner while parked
module bus_arbiter #(
  parameter int unsigned MaxHold = 4,
  parameter logic [2:0]  ParkSel = 3'b110
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] req_i,
  input  logic       lock_i,
  output logic [5:0] gnt_o,
  output logic       s0_o,
  output logic       s1_o,
  output logic       s2_o,
  output logic       bus_valid_o,
  output logic [2:0] owner_o
);

  localparam int unsigned HoldW = (MaxHold > 1) ? $clog2(MaxHold) : 1;
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MaxHold - 1);

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e           state_q, state_d;
  logic [2:0]       owner_q, owner_d;
  logic [5:0]       gnt_q, gnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [HoldW-1:0] hold_q, hold_d;

  // First set bit of mask, searching upward from last+1 and wrapping modulo 6.
  function automatic logic [2:0] rr_pick(input logic [5:0] mask, input logic [2:0] last);
    logic [2:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= 6; i++) begin
      idx = (32'(last) + i) % 6;
      if (!found && mask[idx]) begin
        pick  = 3'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  logic [5:0] others;
  logic       do_grant;
  logic [2:0] winner;

  assign others = req_i & ~(6'd1 << owner_q);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    hold_d   = hold_q;
    do_grant = 1'b0;
    winner   = owner_q;

    unique case (state_q)
      StIdle: begin
        if (req_i != 6'd0) begin
          do_grant = 1'b1;
          winner   = rr_pick(req_i, owner_q);
        end
      end
      StOwn: begin
        if (!req_i[owner_q]) begin
          // Release; hand off in the same edge if anyone else waits.
          if (others != 6'd0) begin
            do_grant = 1'b1;
            winner   = rr_pick(others, owner_q);
          end else begin
            state_d = StIdle;
            gnt_d   = 6'd0;
            sel_d   = ParkSel;
          end
        end else if (lock_i) begin
          if (hold_q != HoldMax) hold_d = hold_q + 1'b1;
        end else if (hold_q != HoldMax) begin
          hold_d = hold_q + 1'b1;
        end else if (others != 6'd0) begin
          do_grant = 1'b1;
          winner   = rr_pick(others, owner_q);
        end else begin
          // Tenure expired but nobody waits: start a fresh tenure.
          hold_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_grant) begin
      state_d = StOwn;
      owner_d = winner;
      gnt_d   = 6'd1 << winner;
      sel_d   = winner;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      owner_q <= 3'd5;
      gnt_q   <= 6'd0;
      sel_q   <= ParkSel;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt_o              = gnt_q;
  assign {s2_o, s1_o, s0_o} = sel_q;
  assign owner_o            = owner_q;
  assign bus_valid_o        = (state_q == StOwn);

endmodule
